voice_scheduler: RTL and testbench
==================================

// Module: voice_scheduler
// PURPOSE
//  Sequences the three note voices of the harmonic chord player. Accepts note and
//  wait commands from the song reader and assigns each note to a free voice. When all
//  voices are busy it steals the oldest one. It times the wait periods in beats and
//  reports when the wait is over. Sits between song_reader and the per-voice note players.
// PARAMETERS
//  NUM_VOICES  3  number of note voices managed (2..4)
//  NOTE_W      6  note code width; code 0 = rest
//  DUR_W       6  duration width, in beats (1/48 s)
// PORTS
//  clk             in   1         system clock
//  reset_n         in   1         asynchronous, active-low reset
//  flush           in   1         synchronous clear, driven from MCU reset_player
//  play            in   1         high = time advances; low = wait counter frozen
//  beat            in   1         one-cycle beat pulse from beat_generator
//  load_new_note   in   1         one-cycle note command from song_reader
//  activate        in   1         one-cycle wait command from song_reader
//  note_in         in   NOTE_W    note code, valid with load_new_note
//  duration_in     in   DUR_W     note length or wait length, valid with load/activate
//  voice_done      in   NUM_VOICES  per-voice level, high = voice finished/idle
//  voice_load      out  NUM_VOICES  one-hot, one-cycle load strobe to a voice
//  voice_note      out  NOTE_W    registered note for the strobed voice
//  voice_duration  out  DUR_W     registered duration for the strobed voice
//  activate_done   out  1         one-cycle pulse when a wait completes
//  note_done       out  1         level, high when no voice is busy
//  steal           out  1         one-cycle pulse, coincident with a stealing voice_load
//  overrun         out  1         one-cycle pulse, a command was dropped
// BEHAVIOUR
//  Reset (reset_n=0, async) and flush (sync) give the same state:
//   - state IDLE; busy, age and wait counter all 0
//   - all outputs 0 except note_done=1
//   - flush never produces activate_done
//  FSM states IDLE, ALLOC, WAIT. Commands are accepted only in IDLE.
//  IDLE:
//   - load_new_note with note_in!=0 -> ALLOC; note and duration are latched
//   - load_new_note with note_in==0 (rest) is consumed with no voice_load
//   - activate alone -> WAIT; cnt<=duration_in
//   - load and activate in the same cycle: the note is latched, activate is held
//     pending, and WAIT is entered directly after ALLOC
//  ALLOC (exactly 1 cycle): voice selection
//   - pick the lowest-index voice with busy=0
//   - if every voice is busy, pick the voice with the largest age (ties -> lowest
//     index) and pulse steal
//   - pulse voice_load[k] with voice_note and voice_duration valid in the same cycle
//   - latency: load_new_note in cycle t gives voice_load in cycle t+1
//  Voice tracking
//   - allocated voice: busy[k]<=1, age[k]<=0
//   - every other busy voice: age += 1, saturating at 3
//   - busy[k] clears when voice_done[k]=1, but voice_done[k] is ignored in the load
//     cycle and the cycle after it (stale-done guard)
//   - note_done = ~|busy
//  WAIT (activate_done timing)
//   - cnt decrements on beat && play
//   - when cnt==0: pulse activate_done, return to IDLE
//   - duration_in==0: activate_done is 1 cycle after entering WAIT
//   - play=0: cnt holds, and a beat on that cycle is lost
//  overrun pulses for any load_new_note or activate seen in ALLOC or WAIT. That
//  command is dropped and state is unchanged.
//  Widths: cnt is DUR_W bits and never underflows; age is 2 bits per voice.
// STRUCTURE
//  - Shared include music_defs.vh holds: FSM state encodings (IDLE=0, ALLOC=1,
//    WAIT=2), NOTE_REST=0, and the AGE_MAX=3 constant.
//  - One combinational sub-module, voice_pick: inputs busy and age vectors; outputs
//    the one-hot selection and a steal flag.
//  - This module holds the FSM, busy/age/guard registers, wait counter and output
//    registers.
// TESTING
//  1. Reset release, then note 20 dur 8 -> voice_load=001 at t+1, note_done=0;
//     voice_done[0] rises -> note_done=1.
//  2. Notes 10, 12, 14 at 3-cycle spacing -> voice_load 001, 010, 100; a 4th note 16
//     -> voice_load=001 with steal=1 (voice 0 is oldest).
//  3. activate dur 3, play=1, 3 beats -> activate_done exactly 1 cycle after the cycle
//     in which the 3rd beat was sampled; dur 0 -> activate_done 1 cycle after WAIT entry.
//  4. activate dur 4, drop play after 2 beats, send 5 beats, raise play, then 2 beats
//     -> activate_done only after the final beat.
//  5. load_new_note during WAIT -> overrun=1, no voice_load; load+activate in the same
//     cycle -> voice_load then WAIT, no overrun.
//  6. flush, and separately reset_n=0, during WAIT with 2 voices busy -> IDLE,
//     note_done=1, no activate_done; the next note goes to voice 0.

Source files
------------

// File: rtl/voice_scheduler_pkg.sv
// Shared types and constants for the chord-player voice scheduler.
package voice_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALLOC = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam int         NOTE_REST  = 0;
   localparam int         AGE_W      = 2;
   localparam logic [1:0] AGE_MAX    = 2'd3;
   localparam logic [1:0] GUARD_LOAD = 2'd2;

endpackage

// File: rtl/voice_scheduler_voice_pick.sv
// Voice selection: lowest free voice, otherwise the oldest busy one (ties to the
// lowest index) with a steal flag.
module voice_pick
   import voice_scheduler_pkg::*;
#(
   parameter int NUM_VOICES = 3
)
(
   input  logic [NUM_VOICES-1:0]       i_busy,
   input  logic [AGE_W*NUM_VOICES-1:0] i_age,
   output logic [NUM_VOICES-1:0]       o_sel,
   output logic                        o_steal
);

   logic             w_found;
   logic [1:0]       w_best_idx;
   logic [AGE_W-1:0] w_best_age;

   always_comb begin
      o_sel      = '0;
      o_steal    = 1'b0;
      w_found    = 1'b0;
      w_best_idx = 2'd0;
      w_best_age = i_age[AGE_W-1:0];
      for (int k = 0; k < NUM_VOICES; k++) begin
         if (!i_busy[k] && !w_found) begin
            o_sel[k] = 1'b1;
            w_found  = 1'b1;
         end
      end
      if (!w_found) begin
         o_steal = 1'b1;
         // strict '>' keeps the lowest index on equal ages
         for (int k = 1; k < NUM_VOICES; k++) begin
            if (i_age[k*AGE_W +: AGE_W] > w_best_age) begin
               w_best_age = i_age[k*AGE_W +: AGE_W];
               w_best_idx = 2'(k);
            end
         end
         for (int k = 0; k < NUM_VOICES; k++) begin
            o_sel[k] = (w_best_idx == 2'(k));
         end
      end
   end

endmodule

// File: rtl/voice_scheduler.sv
// Assigns note commands to voices (stealing the oldest when full) and times
// wait commands in beats.
//   state    | meaning
//   ST_IDLE  | accepting note / wait commands
//   ST_ALLOC | one cycle, voice_load strobe out
//   ST_WAIT  | counting beats until the wait ends
module voice_scheduler
   import voice_scheduler_pkg::*;
#(
   parameter int NUM_VOICES = 3,
   parameter int NOTE_W     = 6,
   parameter int DUR_W      = 6
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  play,
   input  logic                  beat,
   input  logic                  load_new_note,
   input  logic                  activate,
   input  logic [NOTE_W-1:0]     note_in,
   input  logic [DUR_W-1:0]      duration_in,
   input  logic [NUM_VOICES-1:0] voice_done,
   output logic [NUM_VOICES-1:0] voice_load,
   output logic [NOTE_W-1:0]     voice_note,
   output logic [DUR_W-1:0]      voice_duration,
   output logic                  activate_done,
   output logic                  note_done,
   output logic                  steal,
   output logic                  overrun
);

   state_t                      r_state;
   logic [NUM_VOICES-1:0]       r_busy;
   logic [AGE_W*NUM_VOICES-1:0] r_age;
   logic [2*NUM_VOICES-1:0]     r_guard;
   logic [DUR_W-1:0]            r_cnt;
   logic                        r_pend;
   logic [NUM_VOICES-1:0]       r_voice_load;
   logic [NOTE_W-1:0]           r_voice_note;
   logic [DUR_W-1:0]            r_voice_duration;
   logic                        r_act_done;
   logic                        r_steal;
   logic                        r_overrun;

   logic [NUM_VOICES-1:0]       w_sel;
   logic                        w_steal;
   logic                        w_is_note;

   assign w_is_note = load_new_note && (note_in != NOTE_W'(NOTE_REST));

   voice_pick #(.NUM_VOICES(NUM_VOICES)) u_pick (
      .i_busy  (r_busy),
      .i_age   (r_age),
      .o_sel   (w_sel),
      .o_steal (w_steal)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state          <= ST_IDLE;
         r_busy           <= '0;
         r_age            <= '0;
         r_guard          <= '0;
         r_cnt            <= '0;
         r_pend           <= 1'b0;
         r_voice_load     <= '0;
         r_voice_note     <= '0;
         r_voice_duration <= '0;
         r_act_done       <= 1'b0;
         r_steal          <= 1'b0;
         r_overrun        <= 1'b0;
      end else if (flush) begin
         r_state          <= ST_IDLE;
         r_busy           <= '0;
         r_age            <= '0;
         r_guard          <= '0;
         r_cnt            <= '0;
         r_pend           <= 1'b0;
         r_voice_load     <= '0;
         r_voice_note     <= '0;
         r_voice_duration <= '0;
         r_act_done       <= 1'b0;
         r_steal          <= 1'b0;
         r_overrun        <= 1'b0;
      end else begin
         r_voice_load <= '0;
         r_steal      <= 1'b0;
         r_act_done   <= 1'b0;
         r_overrun    <= 1'b0;

         // the guard masks a done level left over from the voice's previous note
         for (int k = 0; k < NUM_VOICES; k++) begin
            if (r_guard[2*k +: 2] != 2'd0) begin
               r_guard[2*k +: 2] <= r_guard[2*k +: 2] - 2'd1;
            end else if (voice_done[k]) begin
               r_busy[k] <= 1'b0;
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (w_is_note) begin
                  r_state          <= ST_ALLOC;
                  r_voice_load     <= w_sel;
                  r_voice_note     <= note_in;
                  r_voice_duration <= duration_in;
                  r_steal          <= w_steal;
                  r_pend           <= activate;
                  if (activate) begin
                     r_cnt <= duration_in;
                  end
                  for (int k = 0; k < NUM_VOICES; k++) begin
                     if (w_sel[k]) begin
                        r_busy[k]             <= 1'b1;
                        r_age[AGE_W*k +: AGE_W] <= '0;
                        r_guard[2*k +: 2]     <= GUARD_LOAD;
                     end else if (r_busy[k] && r_age[AGE_W*k +: AGE_W] != AGE_MAX) begin
                        r_age[AGE_W*k +: AGE_W] <= r_age[AGE_W*k +: AGE_W] + 2'd1;
                     end
                  end
               end else if (activate) begin
                  r_state <= ST_WAIT;
                  r_cnt   <= duration_in;
               end
            end
            ST_ALLOC: begin
               r_overrun <= load_new_note || activate;
               r_state   <= r_pend ? ST_WAIT : ST_IDLE;
               r_pend    <= 1'b0;
            end
            ST_WAIT: begin
               r_overrun <= load_new_note || activate;
               if (r_cnt == '0) begin
                  r_act_done <= 1'b1;
                  r_state    <= ST_IDLE;
               end else if (beat && play) begin
                  r_cnt <= r_cnt - DUR_W'(1);
                  if (r_cnt == DUR_W'(1)) begin
                     r_act_done <= 1'b1;
                     r_state    <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign voice_load     = r_voice_load;
   assign voice_note     = r_voice_note;
   assign voice_duration = r_voice_duration;
   assign activate_done  = r_act_done;
   assign steal          = r_steal;
   assign overrun        = r_overrun;
   assign note_done      = ~|r_busy;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: allocation, stealing, wait timing,
// overrun, flush and async reset.
module tb_voice_scheduler;

   localparam int NV = 3;
   localparam int NW = 6;
   localparam int DW = 6;

   logic          clk           = 1'b0;
   logic          reset_n       = 1'b0;
   logic          flush         = 1'b0;
   logic          play          = 1'b0;
   logic          beat          = 1'b0;
   logic          load_new_note = 1'b0;
   logic          activate      = 1'b0;
   logic [NW-1:0] note_in       = '0;
   logic [DW-1:0] duration_in   = '0;
   logic [NV-1:0] voice_done    = '0;

   logic [NV-1:0] voice_load;
   logic [NW-1:0] voice_note;
   logic [DW-1:0] voice_duration;
   logic          activate_done;
   logic          note_done;
   logic          steal;
   logic          overrun;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   voice_scheduler #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .flush          (flush),
      .play           (play),
      .beat           (beat),
      .load_new_note  (load_new_note),
      .activate       (activate),
      .note_in        (note_in),
      .duration_in    (duration_in),
      .voice_done     (voice_done),
      .voice_load     (voice_load),
      .voice_note     (voice_note),
      .voice_duration (voice_duration),
      .activate_done  (activate_done),
      .note_done      (note_done),
      .steal          (steal),
      .overrun        (overrun)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_note(input int n, input int d);
      load_new_note = 1'b1;
      note_in       = NW'(n);
      duration_in   = DW'(d);
      cyc();
      load_new_note = 1'b0;
   endtask

   task automatic send_act(input int d);
      activate    = 1'b1;
      duration_in = DW'(d);
      cyc();
      activate    = 1'b0;
   endtask

   task automatic beat_cycle();
      beat = 1'b1;
      cyc();
      beat = 1'b0;
   endtask

   initial begin
      play = 1'b1;
      repeat (3) cyc();
      check_val("rst_load",  32'(voice_load), 0);
      check_val("rst_adone", 32'(activate_done), 0);
      check_val("rst_ndone", 32'(note_done), 1);
      check_val("rst_steal", 32'(steal), 0);
      check_val("rst_ovr",   32'(overrun), 0);
      reset_n = 1'b1;
      cyc();

      // single note, then stale-done guard and release
      send_note(20, 8);
      check_val("t1_load",  32'(voice_load), 1);
      check_val("t1_note",  32'(voice_note), 20);
      check_val("t1_dur",   32'(voice_duration), 8);
      check_val("t1_ndone", 32'(note_done), 0);
      check_val("t1_steal", 32'(steal), 0);
      cyc();
      check_val("t1_load_off", 32'(voice_load), 0);
      voice_done = 3'b001;
      cyc();
      check_val("t1_guard", 32'(note_done), 0);
      cyc();
      check_val("t1_free", 32'(note_done), 1);
      voice_done = 3'b000;

      // fill three voices, fourth note steals voice 0
      send_note(10, 5);
      check_val("t2_v0", 32'(voice_load), 1);
      check_val("t2_v0_steal", 32'(steal), 0);
      repeat (2) cyc();
      send_note(12, 5);
      check_val("t2_v1", 32'(voice_load), 2);
      repeat (2) cyc();
      send_note(14, 5);
      check_val("t2_v2", 32'(voice_load), 4);
      check_val("t2_v2_steal", 32'(steal), 0);
      repeat (2) cyc();
      send_note(16, 7);
      check_val("t2_steal_load", 32'(voice_load), 1);
      check_val("t2_steal", 32'(steal), 1);
      check_val("t2_steal_note", 32'(voice_note), 16);
      voice_done = 3'b111;
      repeat (3) cyc();
      check_val("t2_all_free", 32'(note_done), 1);
      voice_done = 3'b000;

      // wait of 3 beats, then zero-length wait
      send_act(3);
      beat_cycle();
      check_val("t3_b1", 32'(activate_done), 0);
      cyc();
      beat_cycle();
      check_val("t3_b2", 32'(activate_done), 0);
      beat_cycle();
      check_val("t3_done", 32'(activate_done), 1);
      cyc();
      check_val("t3_done_off", 32'(activate_done), 0);
      send_act(0);
      check_val("t3_z_entry", 32'(activate_done), 0);
      cyc();
      check_val("t3_z_done", 32'(activate_done), 1);
      cyc();

      // beats lost while play is low
      send_act(4);
      beat_cycle();
      beat_cycle();
      play = 1'b0;
      for (int i = 0; i < 5; i++) begin
         beat_cycle();
         check_val("t4_paused", 32'(activate_done), 0);
      end
      play = 1'b1;
      beat_cycle();
      check_val("t4_b3", 32'(activate_done), 0);
      beat_cycle();
      check_val("t4_done", 32'(activate_done), 1);
      cyc();

      // overrun during WAIT, then note+wait together
      send_act(5);
      load_new_note = 1'b1;
      note_in       = NW'(30);
      duration_in   = DW'(9);
      beat          = 1'b1;
      cyc();
      load_new_note = 1'b0;
      beat          = 1'b0;
      check_val("t5_ovr", 32'(overrun), 1);
      check_val("t5_ovr_noload", 32'(voice_load), 0);
      for (int i = 0; i < 3; i++) beat_cycle();
      check_val("t5_ovr_off", 32'(overrun), 0);
      check_val("t5_b4", 32'(activate_done), 0);
      beat_cycle();
      check_val("t5_wait_done", 32'(activate_done), 1);
      cyc();
      load_new_note = 1'b1;
      activate      = 1'b1;
      note_in       = NW'(22);
      duration_in   = DW'(2);
      cyc();
      load_new_note = 1'b0;
      activate      = 1'b0;
      check_val("t5_both_load", 32'(voice_load), 1);
      check_val("t5_both_ovr", 32'(overrun), 0);
      cyc();
      check_val("t5_both_ovr2", 32'(overrun), 0);
      beat_cycle();
      check_val("t5_both_b1", 32'(activate_done), 0);
      beat_cycle();
      check_val("t5_both_done", 32'(activate_done), 1);
      cyc();

      // flush during WAIT with voices 0 and 1 busy
      send_note(40, 3);
      check_val("t6_v1", 32'(voice_load), 2);
      cyc();
      send_act(10);
      beat_cycle();
      check_val("t6_busy", 32'(note_done), 0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      check_val("t6_fl_ndone", 32'(note_done), 1);
      check_val("t6_fl_adone", 32'(activate_done), 0);
      for (int i = 0; i < 3; i++) begin
         beat_cycle();
         check_val("t6_fl_idle", 32'(activate_done), 0);
      end
      send_note(41, 2);
      check_val("t6_fl_next", 32'(voice_load), 1);
      cyc();

      // async reset during WAIT with voices 0 and 1 busy
      send_note(42, 2);
      check_val("t6_v1b", 32'(voice_load), 2);
      cyc();
      send_act(10);
      beat_cycle();
      check_val("t6_busy2", 32'(note_done), 0);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("t6_rst_ndone", 32'(note_done), 1);
      check_val("t6_rst_adone", 32'(activate_done), 0);
      cyc();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         beat_cycle();
         check_val("t6_rst_idle", 32'(activate_done), 0);
      end
      send_note(43, 2);
      check_val("t6_rst_next", 32'(voice_load), 1);
      check_val("t6_rst_steal", 32'(steal), 0);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
